ahb_arbiter: RTL

//  Multi-master AHB bus arbiter. Drives the arbitration signals of the shared AHB interface:

---
 rtl/ahb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter: registered HGRANT/HMASTER/HMASTLOCK, round-robin by default or
// lowest-index-wins when AHB_ARB_FIXED_PRIO_EN is defined; handles bursts, locks and SPLIT/RETRY.
module ahb_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                       HTRANS,
    input  logic [2:0]                       HBURST,
    input  logic                             HREADY,
    input  logic [1:0]                       HRESP,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
    output logic                             HMASTLOCK
);
    localparam int                       IW       = $clog2(NO_OF_MASTERS);
    localparam logic [IW-1:0]            DEF_IDX  = IW'(DEFAULT_MASTER);
    localparam logic [NO_OF_MASTERS-1:0] ONE_BIT  = {{(NO_OF_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NO_OF_MASTERS-1:0] DEF_BIT  = ONE_BIT << DEFAULT_MASTER;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [1:0] RSP_RETRY = 2'd2;
    localparam logic [1:0] RSP_SPLIT = 2'd3;

    typedef enum logic [1:0] {S_DEFAULT, S_GRANTED, S_BURST, S_LOCKED} state_t;

    state_t                   r_state, w_state_nxt;
    logic [NO_OF_MASTERS-1:0] r_grant, r_split_mask;
    logic [NO_OF_MASTERS-1:0] w_split_set, w_eligible, w_new_grant;
    logic [IW-1:0]            r_owner, r_master, r_rr_ptr, w_win_idx, w_new_idx;
    logic                     r_mastlock, w_win_found, w_retry, w_rearb;
    logic                     w_own_phase, w_fixed_burst;
    logic [3:0]               r_burst_left, w_burst_len;
    int                       w_cand;

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

    assign w_retry       = HREADY && (HRESP == RSP_RETRY || HRESP == RSP_SPLIT);
    assign w_own_phase   = (r_master == r_owner);
    assign w_fixed_burst = (HBURST >= 3'd2);
    assign w_eligible    = HBUSREQ & ~(r_split_mask | w_split_set);
    assign w_new_idx     = w_win_found ? w_win_idx : DEF_IDX;
    assign w_new_grant   = ONE_BIT << w_new_idx;

    // A split master is excluded from the arbitration on the very edge that masks it.
    always_comb begin
        w_split_set = '0;
        if (HREADY && HRESP == RSP_SPLIT)
            w_split_set[r_master] = 1'b1;
        w_split_set = w_split_set & ~HSPLIT & ~DEF_BIT;
    end

    always_comb begin
        case (HBURST)
            3'd2, 3'd3: w_burst_len = 4'd3;
            3'd4, 3'd5: w_burst_len = 4'd7;
            3'd6, 3'd7: w_burst_len = 4'd15;
            default:    w_burst_len = 4'd0;
        endcase
    end

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = DEF_IDX;
        w_cand      = 0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
            w_cand = i;
`else
            w_cand = (int'(r_rr_ptr) + 1 + i) % NO_OF_MASTERS;
`endif
            if (!w_win_found && w_eligible[IW'(w_cand)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(w_cand);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rearb     = 1'b0;
        if (HREADY) begin
            if (w_retry) begin
                w_rearb = 1'b1;
            end else begin
                case (r_state)
                    S_DEFAULT: w_rearb = |w_eligible;
                    S_LOCKED: begin
                        // Lock release keeps the grant for one more transfer.
                        if (!HLOCK[r_owner])
                            w_state_nxt = S_GRANTED;
                    end
                    default: begin
                        if (r_state == S_BURST && r_burst_left > 4'd1)
                            w_state_nxt = S_BURST;
                        else if (HLOCK[r_owner])
                            w_state_nxt = S_LOCKED;
                        else if (w_own_phase && HTRANS == TR_NONSEQ && w_fixed_burst)
                            w_state_nxt = S_BURST;
                        else if (!HBUSREQ[r_owner])
                            w_rearb = 1'b1;
                        else
                            w_state_nxt = S_GRANTED;
                    end
                endcase
            end
            if (w_rearb)
                w_state_nxt = w_win_found ? S_GRANTED : S_DEFAULT;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_state <= S_DEFAULT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_grant      <= DEF_BIT;
            r_owner      <= DEF_IDX;
            r_master     <= DEF_IDX;
            r_mastlock   <= 1'b0;
            r_rr_ptr     <= DEF_IDX;
            r_split_mask <= '0;
            r_burst_left <= '0;
        end else begin
            r_split_mask <= (r_split_mask | w_split_set) & ~HSPLIT;
            if (HREADY) begin
                r_master   <= r_owner;
                r_mastlock <= HLOCK[r_owner];
                case (HTRANS)
                    TR_NONSEQ: r_burst_left <= w_burst_len;
                    TR_SEQ:    if (r_burst_left != 4'd0) r_burst_left <= r_burst_left - 4'd1;
                    TR_IDLE:   r_burst_left <= '0;
                    default:   ;
                endcase
                if (w_rearb) begin
                    r_owner <= w_new_idx;
                    r_grant <= w_new_grant;
                    if (w_new_idx != r_owner)
                        r_rr_ptr <= w_new_idx;
                end
            end
        end
    end
endmodule
